// File: rtl/wps_stream_mux_if.sv
// Source-side and transmit-side signal bundle for the WPS read-path stream selector.
interface wps_stream_mux_if #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned SEL_W   = 2,
   parameter int unsigned DATA_W  = 288
);
   logic [NUM_SRC-1:0]        src_start_in;
   logic [NUM_SRC-1:0]        src_done_in;
   logic [NUM_SRC*DATA_W-1:0] src_data_in;
   logic [NUM_SRC-1:0]        src_valid_in;
   logic [NUM_SRC-1:0]        src_req_out;
   logic [DATA_W-1:0]         tx_data_out;
   logic                      tx_valid_out;
   logic                      tx_ready_in;
   logic [SEL_W-1:0]          active_src_out;
   logic                      busy_out;
   logic [31:0]               beat_count_out;
   logic                      err_overlap_out;

   // Selector side: consumes source streams and downstream ready, drives everything else.
   modport master (
      input  src_start_in, src_done_in, src_data_in, src_valid_in, tx_ready_in,
      output src_req_out, tx_data_out, tx_valid_out, active_src_out, busy_out,
      output beat_count_out, err_overlap_out
   );

   // Environment side: memory readers plus the width converter.
   modport slave (
      output src_start_in, src_done_in, src_data_in, src_valid_in, tx_ready_in,
      input  src_req_out, tx_data_out, tx_valid_out, active_src_out, busy_out,
      input  beat_count_out, err_overlap_out
   );
endinterface

// File: rtl/wps_stream_mux.sv
// Session-based N-source stream selector with a 2-entry registered output buffer.
module wps_stream_mux #(
   parameter int unsigned NUM_SRC     = 4,
   parameter int unsigned SEL_W       = 2,
   parameter int unsigned DATA_W      = 288,
   parameter int unsigned DEFAULT_SRC = 0
) (
   input  logic             mem_clk,
   input  logic             mem_rst_n,
   wps_stream_mux_if.master bus
);
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned FILL_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [DATA_W-1:0]   head_q, head_d;
   logic [DATA_W-1:0]   tail_q, tail_d;
   logic                tx_valid_q, tx_valid_d;
   logic [NUM_SRC-1:0]  req_q, req_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic                err_q, err_d;

   logic                any_start_c;
   logic                found_c;
   logic [SEL_W-1:0]    win_c;
   logic                sel_valid_c;
   logic                sel_done_c;
   logic                sel_req_c;
   logic [DATA_W-1:0]   sel_data_c;
   logic                push_c;
   logic                pop_c;

   // Start arbitration (lowest index wins) and selected-source view.
   always_comb begin
      any_start_c = |bus.src_start_in;
      found_c     = 1'b0;
      win_c       = SEL_W'(DEFAULT_SRC);
      sel_valid_c = 1'b0;
      sel_done_c  = 1'b0;
      sel_req_c   = 1'b0;
      sel_data_c  = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (bus.src_start_in[i] && !found_c) begin
            win_c   = SEL_W'(i);
            found_c = 1'b1;
         end
         if (sel_q == SEL_W'(i)) begin
            sel_valid_c = bus.src_valid_in[i];
            sel_done_c  = bus.src_done_in[i];
            sel_req_c   = req_q[i];
            sel_data_c  = bus.src_data_in[i*DATA_W +: DATA_W];
         end
      end
      push_c = (state_q == ST_ACTIVE) && sel_valid_c && sel_req_c;
      pop_c  = tx_valid_q && bus.tx_ready_in;
   end

   // Session state register.
   always_ff @(posedge mem_clk) begin
      if (!mem_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Session next-state: drain leaves only once the buffer has been seen empty.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (any_start_c) state_d = ST_ACTIVE;
         ST_ACTIVE: if (sel_done_c) state_d = ST_DRAIN;
         ST_DRAIN:  if (fill_q == '0) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Buffer, selection, counters and status next values.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      fill_d = fill_q;
      case ({push_c, pop_c})
         2'b10: begin
            if (fill_q == '0) begin
               head_d = sel_data_c;
               fill_d = FILL_W'(1);
            end else begin
               tail_d = sel_data_c;
               fill_d = FILL_W'(2);
            end
         end
         2'b01: begin
            if (fill_q == FILL_W'(2)) head_d = tail_q;
            fill_d = fill_q - FILL_W'(1);
         end
         2'b11: begin
            if (fill_q == FILL_W'(2)) begin
               head_d = tail_q;
               tail_d = sel_data_c;
            end else begin
               head_d = sel_data_c;
            end
         end
         default: ;
      endcase
      tx_valid_d = (fill_d != '0);

      sel_d = sel_q;
      if ((state_q == ST_IDLE) && any_start_c) begin
         sel_d = win_c;
      end else if (state_d == ST_IDLE) begin
         sel_d = SEL_W'(DEFAULT_SRC);
      end

      beat_cnt_d = beat_cnt_q;
      if ((state_q == ST_IDLE) && any_start_c) begin
         beat_cnt_d = '0;
      end else if (push_c) begin
         beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end

      req_d = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if ((state_d == ST_ACTIVE) && (fill_d != FILL_W'(2)) && (sel_d == SEL_W'(i))) begin
            req_d[i] = 1'b1;
         end
      end

      busy_d = (state_d != ST_IDLE);
      err_d  = (state_q != ST_IDLE) && any_start_c;
   end

   // Datapath and status registers.
   always_ff @(posedge mem_clk) begin
      if (!mem_rst_n) begin
         sel_q      <= SEL_W'(DEFAULT_SRC);
         fill_q     <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         tx_valid_q <= 1'b0;
         req_q      <= '0;
         busy_q     <= 1'b0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         sel_q      <= sel_d;
         fill_q     <= fill_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         tx_valid_q <= tx_valid_d;
         req_q      <= req_d;
         busy_q     <= busy_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
      end
   end

   assign bus.src_req_out     = req_q;
   assign bus.tx_data_out     = head_q;
   assign bus.tx_valid_out    = tx_valid_q;
   assign bus.active_src_out  = sel_q;
   assign bus.busy_out        = busy_q;
   assign bus.beat_count_out  = beat_cnt_q;
   assign bus.err_overlap_out = err_q;
endmodule

// File: tb/tb_wps_stream_mux.sv
// Directed self-checking bench for wps_stream_mux.
module tb_wps_stream_mux;
   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned DATA_W  = 288;

   logic mem_clk;
   logic mem_rst_n;
   int   checks;
   int   failures;

   wps_stream_mux_if #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DATA_W(DATA_W)) bus ();

   wps_stream_mux #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DATA_W(DATA_W), .DEFAULT_SRC(0)) dut (
      .mem_clk   (mem_clk),
      .mem_rst_n (mem_rst_n),
      .bus       (bus)
   );

   initial mem_clk = 1'b0;
   always #5 mem_clk = ~mem_clk;

   // Beat payload tagged with source and beat index.
   function automatic logic [DATA_W-1:0] mk(input int s, input int k);
      logic [31:0] w;
      w = 32'hC0DE_0000 | (32'(s) << 8) | 32'(k);
      return {9{w}};
   endfunction

   task automatic tick();
      @(posedge mem_clk);
      #1;
   endtask

   task automatic clr_inputs();
      bus.src_start_in = '0;
      bus.src_done_in  = '0;
      bus.src_valid_in = '0;
      bus.src_data_in  = '0;
      bus.tx_ready_in  = 1'b1;
   endtask

   task automatic test_reset();
      clr_inputs();
      mem_rst_n = 1'b0;
      tick();
      tick();
      checks++; if (bus.tx_valid_out !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%0b exp=0", bus.tx_valid_out); end
      checks++; if (bus.tx_data_out !== '0) begin failures++; $display("FAIL reset_tx_data got=%h exp=0", bus.tx_data_out); end
      checks++; if (bus.src_req_out !== 4'b0000) begin failures++; $display("FAIL reset_req got=%b exp=0000", bus.src_req_out); end
      checks++; if (bus.active_src_out !== 2'd0) begin failures++; $display("FAIL reset_active got=%0d exp=0", bus.active_src_out); end
      checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy_out); end
      checks++; if (bus.beat_count_out !== 32'd0) begin failures++; $display("FAIL reset_beat_count got=%0d exp=0", bus.beat_count_out); end
      checks++; if (bus.err_overlap_out !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.err_overlap_out); end
      mem_rst_n = 1'b1;
      tick();
      checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", bus.busy_out); end
   endtask

   task automatic test_single_session();
      clr_inputs();
      bus.src_start_in[1] = 1'b1;
      tick();
      bus.src_start_in = '0;
      checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL s1_busy got=%0b exp=1", bus.busy_out); end
      checks++; if (bus.active_src_out !== 2'd1) begin failures++; $display("FAIL s1_active got=%0d exp=1", bus.active_src_out); end
      checks++; if (bus.src_req_out !== 4'b0010) begin failures++; $display("FAIL s1_req got=%b exp=0010", bus.src_req_out); end
      checks++; if (bus.beat_count_out !== 32'd0) begin failures++; $display("FAIL s1_count_clear got=%0d exp=0", bus.beat_count_out); end
      for (int k = 0; k < 8; k++) begin
         bus.src_valid_in[1] = 1'b1;
         bus.src_data_in[1*DATA_W +: DATA_W] = mk(1, k);
         bus.src_done_in[1] = (k == 7);
         tick();
         checks++; if (bus.tx_valid_out !== 1'b1) begin failures++; $display("FAIL s1_tx_valid beat=%0d got=%0b exp=1", k, bus.tx_valid_out); end
         checks++; if (bus.tx_data_out !== mk(1, k)) begin failures++; $display("FAIL s1_tx_data beat=%0d got=%h exp=%h", k, bus.tx_data_out, mk(1, k)); end
         checks++; if (bus.beat_count_out !== 32'(k + 1)) begin failures++; $display("FAIL s1_count beat=%0d got=%0d exp=%0d", k, bus.beat_count_out, k + 1); end
      end
      clr_inputs();
      checks++; if (bus.src_req_out !== 4'b0000) begin failures++; $display("FAIL s1_drain_req got=%b exp=0000", bus.src_req_out); end
      tick();
      checks++; if (bus.tx_valid_out !== 1'b0) begin failures++; $display("FAIL s1_drained got=%0b exp=0", bus.tx_valid_out); end
      checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL s1_busy_drain got=%0b exp=1", bus.busy_out); end
      tick();
      checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL s1_busy_fall got=%0b exp=0", bus.busy_out); end
      checks++; if (bus.active_src_out !== 2'd0) begin failures++; $display("FAIL s1_active_revert got=%0d exp=0", bus.active_src_out); end
      checks++; if (bus.beat_count_out !== 32'd8) begin failures++; $display("FAIL s1_count_hold got=%0d exp=8", bus.beat_count_out); end
   endtask

   task automatic test_start_priority();
      clr_inputs();
      bus.src_start_in = 4'b1100;
      tick();
      bus.src_start_in = '0;
      checks++; if (bus.active_src_out !== 2'd2) begin failures++; $display("FAIL prio_active got=%0d exp=2", bus.active_src_out); end
      checks++; if (bus.src_req_out !== 4'b0100) begin failures++; $display("FAIL prio_req got=%b exp=0100", bus.src_req_out); end
      checks++; if (bus.err_overlap_out !== 1'b0) begin failures++; $display("FAIL prio_err got=%0b exp=0", bus.err_overlap_out); end
      bus.src_valid_in = 4'b1100;
      bus.src_data_in[2*DATA_W +: DATA_W] = mk(2, 0);
      bus.src_data_in[3*DATA_W +: DATA_W] = mk(3, 0);
      bus.src_done_in[2] = 1'b1;
      tick();
      checks++; if (bus.tx_data_out !== mk(2, 0)) begin failures++; $display("FAIL prio_tx_data got=%h exp=%h", bus.tx_data_out, mk(2, 0)); end
      checks++; if (bus.src_req_out[3] !== 1'b0) begin failures++; $display("FAIL prio_req3 got=%0b exp=0", bus.src_req_out[3]); end
      checks++; if (bus.err_overlap_out !== 1'b0) begin failures++; $display("FAIL prio_err_late got=%0b exp=0", bus.err_overlap_out); end
      clr_inputs();
      tick();
      tick();
      checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL prio_end_busy got=%0b exp=0", bus.busy_out); end
   endtask

   task automatic test_backpressure();
      int  sent;
      int  rcvd;
      bit  saw_full;
      bit  ended;
      clr_inputs();
      bus.src_start_in[0] = 1'b1;
      tick();
      bus.src_start_in = '0;
      sent = 0;
      rcvd = 0;
      saw_full = 1'b0;
      ended = 1'b0;
      for (int c = 0; c < 40 && !ended; c++) begin
         bus.tx_ready_in = !(c >= 2 && c < 7);
         bus.src_valid_in[0] = (sent < 6);
         bus.src_data_in[0 +: DATA_W] = mk(0, sent);
         bus.src_done_in[0] = (sent == 5) && bus.src_req_out[0];
         if (bus.tx_valid_out && bus.tx_ready_in) begin
            checks++; if (bus.tx_data_out !== mk(0, rcvd)) begin failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", rcvd, bus.tx_data_out, mk(0, rcvd)); end
            rcvd++;
         end
         if (sent < 6 && bus.tx_valid_out && !bus.src_req_out[0]) saw_full = 1'b1;
         if (sent < 6 && bus.src_req_out[0]) sent++;
         tick();
         if (!bus.busy_out) ended = 1'b1;
      end
      clr_inputs();
      checks++; if (ended !== 1'b1) begin failures++; $display("FAIL bp_timeout got=%0b exp=1", ended); end
      checks++; if (saw_full !== 1'b1) begin failures++; $display("FAIL bp_req_drop got=%0b exp=1", saw_full); end
      checks++; if (rcvd !== 6) begin failures++; $display("FAIL bp_rx_count got=%0d exp=6", rcvd); end
      checks++; if (bus.beat_count_out !== 32'd6) begin failures++; $display("FAIL bp_beat_count got=%0d exp=6", bus.beat_count_out); end
   endtask

   task automatic test_overlap();
      clr_inputs();
      bus.src_start_in[1] = 1'b1;
      tick();
      bus.src_start_in = '0;
      bus.src_valid_in[1] = 1'b1;
      bus.src_data_in[1*DATA_W +: DATA_W] = mk(1, 0);
      tick();
      bus.src_data_in[1*DATA_W +: DATA_W] = mk(1, 1);
      bus.src_start_in[0] = 1'b1;
      tick();
      bus.src_start_in = '0;
      checks++; if (bus.err_overlap_out !== 1'b1) begin failures++; $display("FAIL ovl_err got=%0b exp=1", bus.err_overlap_out); end
      checks++; if (bus.active_src_out !== 2'd1) begin failures++; $display("FAIL ovl_active got=%0d exp=1", bus.active_src_out); end
      checks++; if (bus.tx_data_out !== mk(1, 1)) begin failures++; $display("FAIL ovl_tx_data got=%h exp=%h", bus.tx_data_out, mk(1, 1)); end
      bus.src_data_in[1*DATA_W +: DATA_W] = mk(1, 2);
      bus.src_done_in[1] = 1'b1;
      tick();
      checks++; if (bus.err_overlap_out !== 1'b0) begin failures++; $display("FAIL ovl_err_pulse got=%0b exp=0", bus.err_overlap_out); end
      checks++; if (bus.tx_data_out !== mk(1, 2)) begin failures++; $display("FAIL ovl_continue got=%h exp=%h", bus.tx_data_out, mk(1, 2)); end
      checks++; if (bus.beat_count_out !== 32'd3) begin failures++; $display("FAIL ovl_count got=%0d exp=3", bus.beat_count_out); end
      clr_inputs();
      tick();
      tick();
      checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL ovl_end_busy got=%0b exp=0", bus.busy_out); end
   endtask

   task automatic test_ignore_other();
      clr_inputs();
      bus.src_start_in[0] = 1'b1;
      tick();
      bus.src_start_in = '0;
      bus.src_valid_in[3] = 1'b1;
      bus.src_done_in[3] = 1'b1;
      bus.src_data_in[3*DATA_W +: DATA_W] = mk(3, 9);
      for (int k = 0; k < 3; k++) begin
         bus.src_valid_in[0] = 1'b1;
         bus.src_data_in[0 +: DATA_W] = mk(0, k);
         tick();
         checks++; if (bus.tx_data_out !== mk(0, k)) begin failures++; $display("FAIL ign_tx_data beat=%0d got=%h exp=%h", k, bus.tx_data_out, mk(0, k)); end
      end
      bus.src_valid_in[0] = 1'b0;
      tick();
      checks++; if (bus.tx_valid_out !== 1'b0) begin failures++; $display("FAIL ign_no_src3 got=%0b exp=0", bus.tx_valid_out); end
      checks++; if (bus.beat_count_out !== 32'd3) begin failures++; $display("FAIL ign_count got=%0d exp=3", bus.beat_count_out); end
      checks++; if (bus.src_req_out !== 4'b0001) begin failures++; $display("FAIL ign_req got=%b exp=0001", bus.src_req_out); end
      clr_inputs();
      bus.src_done_in[0] = 1'b1;
      tick();
      clr_inputs();
      tick();
      checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL ign_end_busy got=%0b exp=0", bus.busy_out); end
   endtask

   task automatic test_reset_mid_session();
      clr_inputs();
      bus.src_start_in[2] = 1'b1;
      tick();
      bus.src_start_in = '0;
      bus.tx_ready_in = 1'b0;
      bus.src_valid_in[2] = 1'b1;
      bus.src_data_in[2*DATA_W +: DATA_W] = mk(2, 0);
      tick();
      bus.src_data_in[2*DATA_W +: DATA_W] = mk(2, 1);
      tick();
      bus.src_valid_in = '0;
      checks++; if (bus.src_req_out !== 4'b0000) begin failures++; $display("FAIL rst_full_req got=%b exp=0000", bus.src_req_out); end
      checks++; if (bus.tx_data_out !== mk(2, 0)) begin failures++; $display("FAIL rst_hold_data got=%h exp=%h", bus.tx_data_out, mk(2, 0)); end
      mem_rst_n = 1'b0;
      tick();
      checks++; if (bus.tx_valid_out !== 1'b0) begin failures++; $display("FAIL rst_mid_tx_valid got=%0b exp=0", bus.tx_valid_out); end
      checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0b exp=0", bus.busy_out); end
      checks++; if (bus.beat_count_out !== 32'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", bus.beat_count_out); end
      checks++; if (bus.tx_data_out !== '0) begin failures++; $display("FAIL rst_mid_data got=%h exp=0", bus.tx_data_out); end
      mem_rst_n = 1'b1;
      bus.tx_ready_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (bus.tx_valid_out !== 1'b0) begin failures++; $display("FAIL rst_stale cyc=%0d got=%0b exp=0", c, bus.tx_valid_out); end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      mem_rst_n = 1'b0;
      test_reset();
      test_single_session();
      test_start_priority();
      test_backpressure();
      test_overlap();
      test_ignore_other();
      test_reset_mid_session();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
